// File: rtl/dbg_port_pkg.sv
// Shared definitions for the CPU debug *RAM port responders.
//   - FSM state encoding for the read-modify-write sequencer
//   - BRAM depth in words
//   - byte-enable patterns that select the full-write and read paths
package dbg_port_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RMW_RD = 2'd1;
   localparam logic [1:0] ST_RMW_WR = 2'd2;

   localparam int BRAMWORDS = 4096;

   localparam logic [3:0] WE_FULL = 4'b1111;
   localparam logic [3:0] WE_NONE = 4'b0000;

endpackage

// File: rtl/debug_bram_responder_if.sv
// Bundle of the host-side debug port and the BRAM port-B signals.
//   master : host + BRAM side (drives Dbg_A2/WD2/WE2 and Bram_RD)
//   slave  : the responder (drives Dbg_RD2/Busy/Err/WrCnt and Bram_Addr/WD/WE)
interface debug_bram_responder_if #(
   parameter int ADDR_W = 12,
   parameter int CNT_W  = 16
);
   logic [31:0]       Dbg_A2;
   logic [31:0]       Dbg_WD2;
   logic [3:0]        Dbg_WE2;
   logic [31:0]       Dbg_RD2;
   logic              Dbg_Busy;
   logic              Dbg_Err;
   logic [CNT_W-1:0]  Dbg_WrCnt;
   logic [ADDR_W-1:0] Bram_Addr;
   logic [31:0]       Bram_WD;
   logic              Bram_WE;
   logic [31:0]       Bram_RD;

   modport master (
      output Dbg_A2, Dbg_WD2, Dbg_WE2, Bram_RD,
      input  Dbg_RD2, Dbg_Busy, Dbg_Err, Dbg_WrCnt, Bram_Addr, Bram_WD, Bram_WE
   );

   modport slave (
      input  Dbg_A2, Dbg_WD2, Dbg_WE2, Bram_RD,
      output Dbg_RD2, Dbg_Busy, Dbg_Err, Dbg_WrCnt, Bram_Addr, Bram_WD, Bram_WE
   );
endinterface

// File: rtl/dbg_byte_merge.sv
// Per-byte 32-bit merge: byte i of merged_o comes from new_i when mask_i[i]
// is set, otherwise from old_i. Purely combinational.
//   old_i    : existing word (e.g. BRAM read data)
//   new_i    : incoming write data
//   mask_i   : byte enables
//   merged_o : merged word
module dbg_byte_merge (
   input  logic [31:0] old_i,
   input  logic [31:0] new_i,
   input  logic [3:0]  mask_i,
   output logic [31:0] merged_o
);
   for (genvar gi = 0; gi < 4; gi++) begin : g_byte
      assign merged_o[gi*8 +: 8] = mask_i[gi] ? new_i[gi*8 +: 8] : old_i[gi*8 +: 8];
   end
endmodule

// File: rtl/debug_bram_responder.sv
// Responder for the CPU debug *RAM port in front of BRAM port B.
//   CPU_CLK : clock, all state on posedge
//   CPU_RST : asynchronous active-low reset
//   bus     : slave view of the host debug port and BRAM port B
// Full-word writes go straight to the BRAM; partial writes run a two-cycle
// read-modify-write. Reads return after two cycles, out-of-range accesses
// set a sticky error and read as zero, committed writes are counted.
module debug_bram_responder
   import dbg_port_pkg::*;
#(
   parameter int ADDR_W = $clog2(BRAMWORDS),
   parameter int CNT_W  = 16
) (
   input  logic                  CPU_CLK,
   input  logic                  CPU_RST,
   debug_bram_responder_if.slave bus
);
   logic              in_range;
   logic [ADDR_W-1:0] widx;
   logic              unused_a2_lsb;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wd_q;
   logic [3:0]        mask_q;
   logic              rd_pend_q, rd_oor_q;
   logic [31:0]       rd2_q;
   logic              err_q;
   logic [CNT_W-1:0]  cnt_q;

   logic              latch_d, rd_issue_d, oor_d, commit_d, we_raw_d;
   logic [ADDR_W-1:0] addr_out_d;
   logic [31:0]       wd_out_d;
   logic [31:0]       merged;

   assign in_range      = (bus.Dbg_A2[31:ADDR_W+2] == '0);
   assign widx          = bus.Dbg_A2[ADDR_W+1:2];
   assign unused_a2_lsb = ^bus.Dbg_A2[1:0];

   // BRAM read data arriving in RMW_WR is the old word at addr_q.
   dbg_byte_merge u_merge (
      .old_i   (bus.Bram_RD),
      .new_i   (wd_q),
      .mask_i  (mask_q),
      .merged_o(merged)
   );

   always_comb begin
      state_d    = state_q;
      addr_out_d = widx;
      wd_out_d   = bus.Dbg_WD2;
      we_raw_d   = 1'b0;
      commit_d   = 1'b0;
      latch_d    = 1'b0;
      rd_issue_d = 1'b0;
      oor_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!in_range) begin
               oor_d      = 1'b1;
               rd_issue_d = (bus.Dbg_WE2 == WE_NONE);
            end else if (bus.Dbg_WE2 != WE_NONE && bus.Dbg_WE2 != WE_FULL) begin
               latch_d = 1'b1;
               state_d = ST_RMW_RD;
            end else if (bus.Dbg_WE2 == WE_FULL) begin
               we_raw_d = 1'b1;
               commit_d = 1'b1;
            end else begin
               rd_issue_d = 1'b1;
            end
         end
         ST_RMW_RD: begin
            addr_out_d = addr_q;
            state_d    = ST_RMW_WR;
         end
         ST_RMW_WR: begin
            addr_out_d = addr_q;
            wd_out_d   = merged;
            we_raw_d   = 1'b1;
            commit_d   = 1'b1;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Gating with CPU_RST kills the write strobe the moment reset asserts,
   // including a full write requested combinationally from IDLE.
   assign bus.Bram_WE   = we_raw_d & CPU_RST;
   assign bus.Bram_Addr = addr_out_d;
   assign bus.Bram_WD   = wd_out_d;
   assign bus.Dbg_RD2   = rd2_q;
   assign bus.Dbg_Busy  = (state_q != ST_IDLE);
   assign bus.Dbg_Err   = err_q;
   assign bus.Dbg_WrCnt = cnt_q;

   always_ff @(posedge CPU_CLK or negedge CPU_RST) begin
      if (!CPU_RST) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         wd_q      <= '0;
         mask_q    <= '0;
         rd_pend_q <= 1'b0;
         rd_oor_q  <= 1'b0;
         rd2_q     <= '0;
         err_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q <= state_d;
         if (latch_d) begin
            addr_q <= widx;
            wd_q   <= bus.Dbg_WD2;
            mask_q <= bus.Dbg_WE2;
         end
         // Stage 1 remembers a read was issued; stage 2 captures BRAM data
         // (or zero for an out-of-range read) one cycle later.
         rd_pend_q <= rd_issue_d;
         rd_oor_q  <= oor_d;
         if (rd_pend_q)
            rd2_q <= rd_oor_q ? 32'd0 : bus.Bram_RD;
         if (oor_d)
            err_q <= 1'b1;
         if (commit_d && !(&cnt_q))
            cnt_q <= cnt_q + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_debug_bram_responder.sv
// Directed bench for debug_bram_responder with a behavioural read-first BRAM.
module tb_debug_bram_responder;
   import dbg_port_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   debug_bram_responder_if #(.ADDR_W(12), .CNT_W(16)) bus ();

   debug_bram_responder #(.ADDR_W(12), .CNT_W(16)) dut (
      .CPU_CLK(clk),
      .CPU_RST(rst_n),
      .bus    (bus)
   );

   // Behavioural BRAM port B: word write, registered read (old data on collision).
   logic [31:0] mem [0:4095] = '{default: 32'd0};
   logic [31:0] bram_rd_q = 32'd0;
   always @(posedge clk) begin
      if (bus.Bram_WE)
         mem[bus.Bram_Addr] <= bus.Bram_WD;
      bram_rd_q <= mem[bus.Bram_Addr];
   end
   assign bus.Bram_RD = bram_rd_q;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Called at a negedge: apply inputs, return at the following negedge.
   task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we);
      bus.Dbg_A2  = a;
      bus.Dbg_WD2 = wd;
      bus.Dbg_WE2 = we;
      @(negedge clk);
   endtask

   function automatic logic [31:0] pat(input int i);
      logic [15:0] lo;
      lo = i[15:0];
      return {lo ^ 16'hA5C3, lo ^ 16'h0F0F};
   endfunction

   initial begin
      bus.Dbg_A2  = 32'd0;
      bus.Dbg_WD2 = 32'd0;
      bus.Dbg_WE2 = WE_NONE;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("rst_rd2",   bus.Dbg_RD2,   32'd0);
      check("rst_busy",  bus.Dbg_Busy,  32'd0);
      check("rst_err",   bus.Dbg_Err,   32'd0);
      check("rst_wrcnt", bus.Dbg_WrCnt, 32'd0);
      check("rst_we",    bus.Bram_WE,   32'd0);
      $display("txn reset release");

      // Full write of word 0, then read it back.
      bus.Dbg_A2 = 32'h0; bus.Dbg_WD2 = 32'hDEADBEEF; bus.Dbg_WE2 = WE_FULL;
      #1;
      check("fw_we",   bus.Bram_WE,   32'd1);
      check("fw_addr", bus.Bram_Addr, 32'd0);
      check("fw_wd",   bus.Bram_WD,   32'hDEADBEEF);
      @(negedge clk);
      check("fw_cnt", bus.Dbg_WrCnt, 32'd1);
      $display("txn full write a=0x0 wd=0xdeadbeef");
      drive(32'h0, 32'h0, WE_NONE);
      check("rd_lat1", bus.Dbg_RD2, 32'd0);
      drive(32'h0, 32'h0, WE_NONE);
      check("rd_lat2", bus.Dbg_RD2, 32'hDEADBEEF);
      $display("txn read a=0x0");

      // Partial write over a preloaded word 1.
      drive(32'h4, 32'h11223344, WE_FULL);
      check("pre_cnt", bus.Dbg_WrCnt, 32'd2);
      bus.Dbg_A2 = 32'h4; bus.Dbg_WD2 = 32'h0000CAFE; bus.Dbg_WE2 = 4'b0011;
      #1;
      check("pw_idle_we", bus.Bram_WE, 32'd0);
      @(negedge clk);
      check("pw_busy1", bus.Dbg_Busy, 32'd1);
      check("pw_we1",   bus.Bram_WE,  32'd0);
      drive(32'h0, 32'h0, WE_NONE);
      check("pw_busy2", bus.Dbg_Busy,  32'd1);
      check("pw_we2",   bus.Bram_WE,   32'd1);
      check("pw_addr",  bus.Bram_Addr, 32'd1);
      check("pw_merge", bus.Bram_WD,   32'h1122CAFE);
      check("pw_rd2_hold", bus.Dbg_RD2, 32'hDEADBEEF);
      drive(32'h0, 32'h0, WE_NONE);
      check("pw_busy_end", bus.Dbg_Busy,  32'd0);
      check("pw_cnt",      bus.Dbg_WrCnt, 32'd3);
      check("pw_mem1",     mem[1],        32'h1122CAFE);
      drive(32'h4, 32'h0, WE_NONE);
      drive(32'h0, 32'h0, WE_NONE);
      check("pw_readback", bus.Dbg_RD2, 32'h1122CAFE);
      $display("txn partial write a=0x4 we=0011");

      // Out-of-range write and read.
      bus.Dbg_A2 = 32'h4000; bus.Dbg_WD2 = 32'h12345678; bus.Dbg_WE2 = WE_FULL;
      #1;
      check("oor_we", bus.Bram_WE, 32'd0);
      @(negedge clk);
      check("oor_err", bus.Dbg_Err,   32'd1);
      check("oor_cnt", bus.Dbg_WrCnt, 32'd3);
      drive(32'h4000, 32'h0, WE_NONE);
      drive(32'h0, 32'h0, WE_NONE);
      check("oor_rd0",  bus.Dbg_RD2, 32'd0);
      check("oor_mem0", mem[0],      32'hDEADBEEF);
      drive(32'h8, 32'h55AA55AA, WE_FULL);
      check("oor_sticky", bus.Dbg_Err,   32'd1);
      check("post_cnt",   bus.Dbg_WrCnt, 32'd4);
      $display("txn out-of-range a=0x4000");

      // Asynchronous reset mid-cycle while a full write is being presented.
      bus.Dbg_A2 = 32'hC; bus.Dbg_WD2 = 32'hA0A0A0A0; bus.Dbg_WE2 = WE_FULL;
      #1;
      check("ar_we_pre", bus.Bram_WE, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("ar_we",    bus.Bram_WE,   32'd0);
      check("ar_busy",  bus.Dbg_Busy,  32'd0);
      check("ar_err",   bus.Dbg_Err,   32'd0);
      check("ar_cnt",   bus.Dbg_WrCnt, 32'd0);
      check("ar_rd2",   bus.Dbg_RD2,   32'd0);
      @(negedge clk);
      bus.Dbg_WE2 = WE_NONE;
      rst_n = 1'b1;
      check("ar_mem3", mem[3], 32'd0);
      $display("txn async reset mid-cycle");

      // Stream load of the whole BRAM, then readback sweep.
      for (int i = 0; i < 4096; i++)
         drive(32'(i) << 2, pat(i), WE_FULL);
      check("st_cnt", bus.Dbg_WrCnt, 32'd4096);
      for (int i = 0; i < 4096; i++) begin
         drive(32'(i) << 2, 32'h0, WE_NONE);
         if (i > 0)
            check("st_rd", bus.Dbg_RD2, pat(i - 1));
      end
      drive(32'h0, 32'h0, WE_NONE);
      check("st_rd_last", bus.Dbg_RD2, pat(4095));
      check("st_mem0",    mem[0],      pat(0));
      check("st_mem4095", mem[4095],   pat(4095));
      $display("txn stream load + readback 4096 words");

      // Reset while in RMW_WR: merged word must never land.
      bus.Dbg_A2 = 32'hC; bus.Dbg_WD2 = 32'hFFFFFFFF; bus.Dbg_WE2 = 4'b1000;
      @(negedge clk);
      drive(32'h0, 32'h0, WE_NONE);
      #1;
      check("rr_busy_pre", bus.Dbg_Busy, 32'd1);
      check("rr_we_pre",   bus.Bram_WE,  32'd1);
      rst_n = 1'b0;
      #1;
      check("rr_busy", bus.Dbg_Busy,  32'd0);
      check("rr_we",   bus.Bram_WE,   32'd0);
      check("rr_cnt",  bus.Dbg_WrCnt, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      check("rr_mem3", mem[3], pat(3));
      drive(32'hC, 32'h0, WE_NONE);
      drive(32'h0, 32'h0, WE_NONE);
      check("rr_read", bus.Dbg_RD2,  pat(3));
      check("rr_idle", bus.Dbg_Busy, 32'd0);
      $display("txn reset during RMW_WR");

      // Out-of-range takes priority over a partial write.
      drive(32'h4004, 32'h0BADF00D, 4'b0011);
      check("pri_busy", bus.Dbg_Busy, 32'd0);
      check("pri_err",  bus.Dbg_Err,  32'd1);
      check("pri_cnt",  bus.Dbg_WrCnt, 32'd0);
      $display("txn out-of-range partial write a=0x4004");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
